// File: rtl/peripheral_operand_sequencer_if.sv
// -----------------------------------------------------------------------------
// peripheral_operand_sequencer_if
//
// Groups the byte-source handshake and the downstream operand-write signals
// of the operand sequencer into one bundle.
//
// Signals:
//   byte_in        [7:0]  incoming data byte               (source -> seq)
//   byte_valid            byte_in valid                    (source -> seq)
//   byte_ready            sequencer can accept a byte      (seq -> source)
//   start                 pulse: clear and begin a frame   (source -> seq)
//   ack                   consumer has taken the operands  (source -> seq)
//   inputdata      [7:0]  byte to the operand register     (seq -> sink)
//   loaddata              single-cycle write strobe        (seq -> sink)
//   datainput_i    [3:0]  byte index for the write         (seq -> sink)
//   operands_ready        full frame resident downstream   (seq -> sink)
//   busy                  high while collecting/flushing   (seq -> sink)
//   timeout_err           single-cycle abort pulse         (seq -> sink)
//
// Modports:
//   master : the side that feeds bytes and observes the sequencer
//   slave  : the sequencer itself
// -----------------------------------------------------------------------------
interface peripheral_operand_sequencer_if;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;
  logic       start;
  logic       ack;
  logic [7:0] inputdata;
  logic       loaddata;
  logic [3:0] datainput_i;
  logic       operands_ready;
  logic       busy;
  logic       timeout_err;

  modport master (
    output byte_in, byte_valid, start, ack,
    input  byte_ready, inputdata, loaddata, datainput_i,
           operands_ready, busy, timeout_err
  );

  modport slave (
    input  byte_in, byte_valid, start, ack,
    output byte_ready, inputdata, loaddata, datainput_i,
           operands_ready, busy, timeout_err
  );
endinterface

// File: rtl/peripheral_operand_sequencer.sv
// -----------------------------------------------------------------------------
// peripheral_operand_sequencer
//
// Upstream feeder for the operand-capture stage. Accepts a byte stream over a
// valid/ready handshake and turns it into indexed byte-write pulses that fill
// the 64-bit dataA/dataB operand register. Bytes 0..NBYTES-1 are written per
// frame; after the last write has landed, operands_ready is raised and held
// until ack.
//
// Parameters:
//   NBYTES          bytes per frame, legal range 1..8
//   TIMEOUT_CYCLES  inter-byte timeout limit (only with OPSEQ_TIMEOUT_EN)
//
// Ports:
//   clk     rising-edge system clock
//   reset   synchronous, active-low reset
//   io_bus  peripheral_operand_sequencer_if.slave (handshake + write signals)
//
// Build option:
//   OPSEQ_TIMEOUT_EN  when defined, a frame that stalls for TIMEOUT_CYCLES
//                     consecutive cycles after its first byte is aborted and
//                     timeout_err pulses. When undefined, timeout_err is tied
//                     low and COLLECT waits indefinitely.
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module peripheral_operand_sequencer #(
  parameter int NBYTES         = 8,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                                 clk,
  input  logic                                 reset,
  peripheral_operand_sequencer_if.slave        io_bus
);

  if (NBYTES < 1 || NBYTES > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_config
    $error("peripheral_operand_sequencer: NBYTES must be 1..8 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_FLUSH,
    S_READY
  } state_t;

  localparam logic [3:0] LP_LAST_IDX = 4'(NBYTES - 1);

  state_t     r_state;
  state_t     w_state_next;
  logic [3:0] r_count;
  logic [3:0] w_count_next;
  logic       w_handshake;
  logic       w_load;
  logic       w_timeout_hit;

  logic       r_byte_ready;
  logic       r_loaddata;
  logic       r_operands_ready;
  logic       r_busy;
  logic [7:0] r_inputdata;
  logic [3:0] r_datainput_i;

  // byte_ready is a registered copy of "state is COLLECT", so the handshake
  // can be formed directly from it.
  assign w_handshake = io_bus.byte_valid & r_byte_ready;

  // ---------------------------------------------------------------------------
  // Optional inter-byte timeout
  // ---------------------------------------------------------------------------
`ifdef OPSEQ_TIMEOUT_EN
  localparam int               LP_TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [LP_TW-1:0] LP_TLAST = LP_TW'(TIMEOUT_CYCLES - 1);

  logic [LP_TW-1:0] r_idle_cnt;
  logic             w_idle_run;
  logic             r_timeout_err;

  // Counts only once the frame has its first byte; a start this cycle wins
  // over the timeout, so it also stops the count.
  assign w_idle_run    = (r_state == S_COLLECT) && (r_count != 4'd0) &&
                         !w_handshake && !io_bus.start;
  assign w_timeout_hit = w_idle_run && (r_idle_cnt == LP_TLAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_idle_cnt    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= w_timeout_hit;
      if (w_idle_run && !w_timeout_hit) begin
        r_idle_cnt <= r_idle_cnt + 1'b1;
      end else begin
        r_idle_cnt <= '0;
      end
    end
  end

  assign io_bus.timeout_err = r_timeout_err;
`else
  assign w_timeout_hit      = 1'b0;
  assign io_bus.timeout_err = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of block ordering.
      r_state <= S_IDLE;
      r_count <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state, counter and write strobe
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned, which would infer a latch.
    w_state_next = r_state;
    w_count_next = r_count;
    w_load       = 1'b0;

    if (io_bus.start) begin
      // start beats ack and any same-cycle handshake; that byte is dropped.
      w_state_next = S_COLLECT;
      w_count_next = 4'd0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          w_state_next = S_IDLE;
        end

        S_COLLECT: begin
          if (w_handshake) begin
            w_load       = 1'b1;
            w_count_next = r_count + 4'd1;
            if (r_count == LP_LAST_IDX) begin
              w_state_next = S_FLUSH;
            end
          end else if (w_timeout_hit) begin
            w_state_next = S_IDLE;
            w_count_next = 4'd0;
          end
        end

        // One cycle that lets the final downstream write land before
        // operands_ready is raised.
        S_FLUSH: begin
          w_state_next = S_READY;
        end

        S_READY: begin
          if (io_bus.ack) begin
            w_state_next = S_IDLE;
          end
        end

        default: begin
          w_state_next = S_IDLE;
          w_count_next = 4'd0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------------
  // Status flags are registered from the next state so they line up exactly
  // with the state they describe.
  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: the data/index registers are reset too, because they are
      // visible outputs that must read zero after reset.
      r_byte_ready     <= 1'b0;
      r_loaddata       <= 1'b0;
      r_operands_ready <= 1'b0;
      r_busy           <= 1'b0;
      r_inputdata      <= 8'h00;
      r_datainput_i    <= 4'h0;
    end else begin
      r_byte_ready     <= (w_state_next == S_COLLECT);
      r_busy           <= (w_state_next == S_COLLECT) || (w_state_next == S_FLUSH);
      r_operands_ready <= (w_state_next == S_READY);
      r_loaddata       <= w_load;
      // Data and index hold their last value between writes.
      if (w_load) begin
        r_inputdata   <= io_bus.byte_in;
        r_datainput_i <= r_count;
      end
    end
  end

  assign io_bus.byte_ready     = r_byte_ready;
  assign io_bus.loaddata       = r_loaddata;
  assign io_bus.operands_ready = r_operands_ready;
  assign io_bus.busy           = r_busy;
  assign io_bus.inputdata      = r_inputdata;
  assign io_bus.datainput_i    = r_datainput_i;

endmodule

// File: tb/tb_peripheral_operand_sequencer.sv
// -----------------------------------------------------------------------------
// tb_peripheral_operand_sequencer
//
// Directed bench for peripheral_operand_sequencer (NBYTES=8, TIMEOUT_CYCLES=16).
// Stimulus pushes each expected downstream write (index, byte) into a queue;
// a monitor pops and compares on every loaddata pulse. A small model of the
// downstream 64-bit operand register is built from the write pulses.
// -----------------------------------------------------------------------------
module tb_peripheral_operand_sequencer;

  logic clk = 1'b0;
  logic reset;

  peripheral_operand_sequencer_if bus ();

  peripheral_operand_sequencer #(
    .NBYTES         (8),
    .TIMEOUT_CYCLES (16)
  ) u_dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] idx;
    logic [7:0] data;
  } wr_t;

  wr_t         exp_q[$];
  int          n_checks   = 0;
  int          n_errors   = 0;
  int          n_loads    = 0;
  int          n_timeouts = 0;
  logic [63:0] operand_reg;

  // Downstream operand register: captures at the end of the loaddata cycle.
  always @(posedge clk) begin
    if (!reset) begin
      operand_reg <= '0;
    end else if (bus.loaddata === 1'b1) begin
      operand_reg[int'(bus.datainput_i) * 8 +: 8] <= bus.inputdata;
    end
  end

  // Monitor: every write pulse must match the next expected write.
  always @(negedge clk) begin
    wr_t e;
    if (bus.timeout_err === 1'b1) n_timeouts++;
    if (bus.loaddata === 1'b1) begin
      n_loads++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_write: got idx=%0d data=%h, required no write",
                 bus.datainput_i, bus.inputdata);
      end else begin
        e = exp_q.pop_front();
        if (bus.datainput_i !== e.idx || bus.inputdata !== e.data) begin
          n_errors++;
          $display("FAIL write: got idx=%0d data=%h, required idx=%0d data=%h",
                   bus.datainput_i, bus.inputdata, e.idx, e.data);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_byte_ready"},     64'(bus.byte_ready),     64'd0);
    check({name, "_loaddata"},       64'(bus.loaddata),       64'd0);
    check({name, "_inputdata"},      64'(bus.inputdata),      64'd0);
    check({name, "_datainput_i"},    64'(bus.datainput_i),    64'd0);
    check({name, "_operands_ready"}, 64'(bus.operands_ready), 64'd0);
    check({name, "_busy"},           64'(bus.busy),           64'd0);
    check({name, "_timeout_err"},    64'(bus.timeout_err),    64'd0);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic pulse_ack();
    bus.ack = 1'b1;
    @(negedge clk);
    bus.ack = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the handshake edge,
  // which is the cycle the matching loaddata is visible.
  task automatic send_byte(input logic [7:0] d, input logic [3:0] idx);
    int waited = 0;
    bus.byte_in    = d;
    bus.byte_valid = 1'b1;
    while (bus.byte_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (bus.byte_ready !== 1'b1) begin
      check("byte_ready_wait", 64'(bus.byte_ready), 64'd1);
      bus.byte_valid = 1'b0;
    end else begin
      exp_q.push_back('{idx: idx, data: d});
      @(negedge clk);
      bus.byte_valid = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int to_base;

    reset          = 1'b0;
    bus.byte_in    = 8'h00;
    bus.byte_valid = 1'b0;
    bus.start      = 1'b0;
    bus.ack        = 1'b0;

    // Reset state
    tick(3);
    check_all_zero("reset");
    reset = 1'b1;

    // IDLE ignores bytes
    bus.byte_in    = 8'h99;
    bus.byte_valid = 1'b1;
    tick(2);
    check("idle_byte_ready", 64'(bus.byte_ready), 64'd0);
    check("idle_busy",       64'(bus.busy),       64'd0);
    bus.byte_valid = 1'b0;

    // Frame 1: back-to-back 8'h11..8'h88
    pulse_start();
    check("ready_after_start", 64'(bus.byte_ready), 64'd1);
    check("busy_after_start",  64'(bus.busy),       64'd1);
    for (int i = 0; i < 8; i++) begin
      send_byte(8'((i + 1) * 17), 4'(i));
    end
    check("flush_byte_ready", 64'(bus.byte_ready),     64'd0);
    check("flush_opready",    64'(bus.operands_ready), 64'd0);
    check("flush_busy",       64'(bus.busy),           64'd1);
    tick(1);
    check("ready_opready", 64'(bus.operands_ready), 64'd1);
    check("ready_busy",    64'(bus.busy),           64'd0);
    check("dataA",         64'(operand_reg[31:0]),  64'h44332211);
    check("dataB",         64'(operand_reg[63:32]), 64'h88776655);
    check("f1_drained",    64'(exp_q.size()),       64'd0);
    tick(3);
    check("opready_held", 64'(bus.operands_ready), 64'd1);
    pulse_ack();
    check("ack_opready", 64'(bus.operands_ready), 64'd0);
    check("ack_busy",    64'(bus.busy),           64'd0);
    check("ack_ready",   64'(bus.byte_ready),     64'd0);

    // Frame 2: byte_valid toggling, ack in COLLECT ignored
    base = n_loads;
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      send_byte(8'hA0 + 8'(i), 4'(i));
      if (i == 3) begin
        pulse_ack();
        check("ack_ignored_busy", 64'(bus.busy), 64'd1);
      end else if (i < 7) begin
        tick(1);
      end
    end
    tick(1);
    check("f2_opready", 64'(bus.operands_ready), 64'd1);
    check("f2_loads",   64'(n_loads - base),     64'd8);
    pulse_ack();
    check("f2_ack_opready", 64'(bus.operands_ready), 64'd0);

    // Frame 3: start collides with a handshake after 3 bytes
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      send_byte(8'h31 + 8'(i), 4'(i));
    end
    bus.start      = 1'b1;
    bus.byte_in    = 8'hAA;
    bus.byte_valid = 1'b1;
    @(negedge clk);
    bus.start      = 1'b0;
    bus.byte_valid = 1'b0;
    check("restart_no_load",    64'(bus.loaddata),   64'd0);
    check("restart_byte_ready", 64'(bus.byte_ready), 64'd1);
    send_byte(8'h5C, 4'd0);
    for (int i = 1; i < 8; i++) begin
      send_byte(8'h60 + 8'(i), 4'(i));
    end
    tick(1);
    check("f3_opready", 64'(bus.operands_ready), 64'd1);
    check("f3_byte0",   64'(operand_reg[7:0]),   64'h5C);
    check("f3_byte1",   64'(operand_reg[15:8]),  64'h61);

    // start in READY restarts
    pulse_start();
    check("ready_restart_opready", 64'(bus.operands_ready), 64'd0);
    check("ready_restart_ready",   64'(bus.byte_ready),     64'd1);

    // Reset mid-frame at count=5
    for (int i = 0; i < 5; i++) begin
      send_byte(8'hC0 + 8'(i), 4'(i));
    end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check_all_zero("midframe_reset");
    bus.byte_in    = 8'h77;
    bus.byte_valid = 1'b1;
    tick(3);
    check("post_reset_ready", 64'(bus.byte_ready), 64'd0);
    check("post_reset_busy",  64'(bus.busy),       64'd0);
    bus.byte_valid = 1'b0;

    // Timeout: 2 bytes then silence
    pulse_start();
    send_byte(8'hE1, 4'd0);
    send_byte(8'hE2, 4'd1);
    to_base = n_timeouts;
    tick(15);
    check("pre_timeout_busy", 64'(bus.busy),        64'd1);
    check("pre_timeout_err",  64'(bus.timeout_err), 64'd0);
    tick(1);
`ifdef OPSEQ_TIMEOUT_EN
    check("timeout_pulse",      64'(bus.timeout_err), 64'd1);
    check("timeout_busy",       64'(bus.busy),        64'd0);
    check("timeout_byte_ready", 64'(bus.byte_ready),  64'd0);
    tick(1);
    check("timeout_single",  64'(bus.timeout_err),     64'd0);
    check("timeout_count",   64'(n_timeouts - to_base), 64'd1);
`else
    check("no_timeout_err",  64'(bus.timeout_err), 64'd0);
    check("no_timeout_busy", 64'(bus.busy),        64'd1);
    tick(5);
    check("still_busy",      64'(bus.busy),             64'd1);
    check("timeout_count",   64'(n_timeouts - to_base), 64'd0);
`endif

    check("final_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/peripheral_operand_sequencer.md
# peripheral_operand_sequencer

Upstream feeder for the operand-capture stage: accepts a byte stream over a valid/ready handshake and turns it into the indexed byte-write pulses (`inputdata`, `loaddata`, `datainput_i`) that fill the 64-bit dataA/dataB operand register. It counts bytes 0..NBYTES-1 per frame. Once the last byte is written downstream, it raises `operands_ready` and holds it until acknowledged. It sits between the peripheral byte source (UART/bus bridge) and the operand register inside the peripheral datapath.

## Interface
- `NBYTES`, 8: bytes per frame; legal range 1..8.
- `TIMEOUT_CYCLES`, 1000: inter-byte timeout limit; used only with `OPSEQ_TIMEOUT_EN`.

- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `byte_in`  in  8  incoming data byte.
- `byte_valid`  in  1  `byte_in` valid.
- `byte_ready`  out  1  sequencer can accept a byte; registered.
- `start`  in  1  single-cycle pulse that clears and begins a frame.
- `ack`  in  1  consumer has taken the operands.
- `inputdata`  out  8  byte to the operand register.
- `loaddata`  out  1  single-cycle write strobe.
- `datainput_i`  out  4  byte index for the write.
- `operands_ready`  out  1  full frame is resident downstream.
- `busy`  out  1  high in COLLECT and FLUSH.
- `timeout_err`  out  1  single-cycle abort pulse; constant 0 without the macro.

## Operation
- Reset (`reset`=0 at a clock edge):
  - State goes to IDLE and the byte counter to 0.
  - All outputs go to 0, including `inputdata`=8'h00 and `datainput_i`=4'h0.
- A handshake occurs when `byte_valid` and `byte_ready` are both 1 at a clock edge.
- FSM states:
  - IDLE: `byte_ready`=0. `start` moves to COLLECT with count=0. Bytes are ignored.
  - COLLECT: `byte_ready`=1.
    - Each handshake registers `byte_in`→`inputdata` and `count`→`datainput_i`, pulses `loaddata`, and increments count.
    - The handshake with count=NBYTES-1 moves to FLUSH.
  - FLUSH: one cycle, `byte_ready`=0. It exists to let the final downstream write land. Always moves to READY.
  - READY: `operands_ready`=1, `byte_ready`=0. `ack` moves to IDLE.
- `start` behaviour in other states:
  - In COLLECT, FLUSH or READY, `start` restarts: count=0, state COLLECT, `operands_ready` drops.
  - `start` has priority over `ack` and over a simultaneous handshake. A handshake in the same cycle as `start` completes on the source side, but the byte is discarded and no `loaddata` is issued.
- `ack` outside READY is ignored.
- Counter is 4 bits wide. `datainput_i` never exceeds NBYTES-1, and the counter never wraps within a frame.
- `loaddata` is high for exactly one cycle per accepted byte; there are no back-to-back duplicates. Back-to-back handshakes give one `loaddata` per cycle.
- `inputdata` and `datainput_i` hold their last value when `loaddata`=0.

## Timing
- Handshake at edge t → `loaddata`=1 with `inputdata`/`datainput_i` valid during cycle t+1. The downstream register captures at the end of t+1.
- Final handshake at edge t → `loaddata` in t+1 (FLUSH) → `operands_ready`=1 from t+2.
- `byte_ready` timing:
  - Rises the cycle after `start` is sampled in IDLE.
  - Falls the cycle after the final handshake.
- `ack` sampled at edge t → `operands_ready`=0 and state IDLE from t+1.
- Reset mid-frame aborts immediately. Already-written downstream bytes are not cleared; the downstream reset covers that.
- Minimum frame of 8 bytes with continuous `byte_valid`: 8 cycles of COLLECT, plus FLUSH, so READY 10 cycles after `start`.

## Configuration
- `OPSEQ_TIMEOUT_EN` defined:
  - An inter-byte counter runs in COLLECT once count≥1 and clears on every handshake.
  - After TIMEOUT_CYCLES consecutive cycles without a handshake, the state goes to IDLE, count resets to 0, and `timeout_err` pulses high for 1 cycle.
  - No timeout applies before the first byte.
- `OPSEQ_TIMEOUT_EN` undefined: no timeout counter is built, `timeout_err` is tied to 0, and COLLECT waits indefinitely.

## Test plan
- Reset, then `start`, then 8 bytes 8'h11..8'h88 streamed back-to-back → `loaddata` pulses with `datainput_i`=0..7 and matching bytes; `operands_ready`=1 two cycles after the last handshake; with the operand stage attached, dataA=32'h44332211 and dataB=32'h88776655.
- Bytes with `byte_valid` toggling every other cycle → exactly 8 `loaddata` pulses, no index skipped or repeated; `ack` in READY → IDLE next cycle and `operands_ready`=0.
- `start` asserted after 3 bytes, same cycle as a handshake carrying 8'hAA → no `loaddata` for 8'hAA; the next byte is written with `datainput_i`=0.
- `reset`=0 for one cycle mid-frame (count=5) → all outputs 0 next cycle; `byte_ready` stays 0 until a new `start`.
- With `OPSEQ_TIMEOUT_EN` and TIMEOUT_CYCLES=16: 2 bytes, then idle for 16 cycles → `timeout_err` single pulse, state IDLE; without the macro the same stimulus leaves `busy`=1 and `timeout_err`=0.
